// File: rtl/reg_dump_unit.sv
// Register-file debug dump: walks an inclusive, wrapping address range and streams (addr, data) words.
// Optional build macro REG_DUMP_SKIP_ZERO_EN suppresses words whose register value is zero.
module reg_dump_unit #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   word_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] end_addr;
    logic          last_word;
    logic          skip_word;

    assign last_word = (addr_cnt == end_addr);
    assign rd_addr   = addr_cnt;

`ifdef REG_DUMP_SKIP_ZERO_EN
    assign skip_word = (rd_data == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH: begin
                if (skip_word) state_nxt = last_word ? FINISH : FETCH;
                else           state_nxt = SEND;
            end
            SEND:    if (out_ready) state_nxt = last_word ? FINISH : FETCH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == SEND);
        busy      = (state != IDLE);
        done      = (state == FINISH);
    end

    // The word is captured in FETCH so later register writes cannot disturb a stalled SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            end_addr <= '0;
            out_addr <= '0;
            out_data <= '0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt <= first_addr;
                        end_addr <= last_addr;
                        word_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (skip_word) begin
                        if (!last_word) addr_cnt <= addr_cnt + 1'b1;
                    end else begin
                        out_addr <= addr_cnt;
                        out_data <= rd_data;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (!last_word) addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: a register-file model answers the debug read port,
// expected words are queued at stimulus time and a monitor checks every handshake.
module tb_reg_dump_unit;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [AW:0]   word_cnt;

    logic [DW-1:0] regs [32];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;
    word_t sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int cyc = 0;

    reg_dump_unit #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: done pulses and handshakes sampled on the falling edge
    initial forever begin
        word_t w;
        @(negedge clk);
        if (!rst && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {59'd0, out_addr}, 64'hFFFF);
            end else begin
                w = sb.pop_front();
                chk("out_addr", {59'd0, out_addr}, {59'd0, w.a});
                chk("out_data", {32'd0, out_data}, {32'd0, w.d});
            end
        end
    end

    task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        word_t w;
        a = f;
        for (int k = 0; k < 32; k++) begin
            if (!SKIP || regs[a] != 0) begin
                w.a = a;
                w.d = regs[a];
                sb.push_back(w);
            end
            if (a == l) break;
            a = a + 1'b1;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clk); #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h1111_1111;

        // Reset values
        #12;
        chk("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_word_cnt", {58'd0, word_cnt}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during SEND with a stalled word
        regs[0] = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        d0 = done_cnt;
        pulse_start(5'd0, 5'd31);
        wait_valid();
        chk("midsend_out_data", {32'd0, out_data}, {32'd0, 32'hDEAD_BEEF});
        rst = 1'b1;
        #1;
        chk("midrst_rd_addr", {59'd0, rd_addr}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_addr", {59'd0, out_addr}, 64'd0);
        chk("midrst_out_data", {32'd0, out_data}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_word_cnt", {58'd0, word_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - d0, 64'd0);
        regs[0] = 32'h0;

        // Full dump 0..31, no backpressure
        out_ready = 1'b1;
        d0 = done_cnt;
        push_range(5'd0, 5'd31);
        pulse_start(5'd0, 5'd31);
        wait_done(d0);
        chk("full_done_cycle", done_cyc - start_cyc, SKIP ? 64'd64 : 64'd65);
        chk("full_word_cnt", {58'd0, word_cnt}, SKIP ? 64'd31 : 64'd32);
        chk("full_sb_empty", sb.size(), 64'd0);

        // Wrapping range 30..1
        regs[0] = 32'hA5A5_0000;
        d0 = done_cnt;
        push_range(5'd30, 5'd1);
        pulse_start(5'd30, 5'd1);
        wait_done(d0);
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_word_cnt", {58'd0, word_cnt}, 64'd4);
        chk("wrap_done_pulses", done_cnt - d0, 64'd1);
        chk("wrap_sb_empty", sb.size(), 64'd0);
        chk("wrap_busy_low", {63'd0, busy}, 64'd0);

        // Backpressure while the source register is overwritten
        regs[5] = 32'h1234_5678;
        out_ready = 1'b0;
        d0 = done_cnt;
        push_range(5'd5, 5'd5);
        pulse_start(5'd5, 5'd5);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) regs[5] = 32'hCAFE_F00D;
            @(negedge clk);
            chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
            chk("bp_data_held", {32'd0, out_data}, {32'd0, 32'h1234_5678});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(d0);
        chk("bp_word_cnt", {58'd0, word_cnt}, 64'd1);
        chk("bp_sb_empty", sb.size(), 64'd0);

        // Start while busy is ignored
        d0 = done_cnt;
        push_range(5'd2, 5'd4);
        pulse_start(5'd2, 5'd4);
        @(posedge clk); #1;
        first_addr = 5'd10;
        last_addr  = 5'd12;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_start_word_cnt", {58'd0, word_cnt}, 64'd3);
        chk("busy_start_done_pulses", done_cnt - d0, 64'd1);
        chk("busy_start_sb_empty", sb.size(), 64'd0);

        // Zero-valued registers in range 0..3
        regs[0] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd0;
        regs[3] = 32'd7;
        d0 = done_cnt;
        push_range(5'd0, 5'd3);
        pulse_start(5'd0, 5'd3);
        wait_done(d0);
        chk("zero_word_cnt", {58'd0, word_cnt}, SKIP ? 64'd2 : 64'd4);
        chk("zero_sb_empty", sb.size(), 64'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
